// File: rtl/mul_arb_ctrl.sv
// Two-requester arbiter and sequencer for a shared shift-add multiplier.
// Round-robin on ties, registered outputs, run-length timeout with abort.
module mul_arb_ctrl #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   opa0,
  input  logic [WIDTH-1:0]   opb0,
  input  logic [WIDTH-1:0]   opa1,
  input  logic [WIDTH-1:0]   opb1,
  output logic               gnt0,
  output logic               gnt1,
  output logic               done0,
  output logic               done1,
  output logic [2*WIDTH-1:0] result,
  output logic               err,
  output logic               dp_load,
  output logic               dp_busy,
  output logic               dp_clr,
  output logic [WIDTH-1:0]   dp_opa,
  output logic [WIDTH-1:0]   dp_opb,
  input  logic [2*WIDTH-1:0] dp_mul,
  input  logic               dp_ready
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DONE,
    ABORT
  } state_t;

  state_t        state;
  state_t        nstate;
  logic          take;
  logic          win;
  logic          sel;
  logic          last;
  logic          fresh;
  logic [CW-1:0] cnt;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nstate;
  end

  // Next state and arbitration; the first cycle after reset is a clear slot.
  always_comb begin
    nstate = state;
    take   = 1'b0;
    win    = sel;
    unique case (state)
      IDLE: begin
        if (!fresh && (req0 || req1)) begin
          take   = 1'b1;
          win    = (req0 && req1) ? ~last : req1;
          nstate = LOAD;
        end
      end
      LOAD: nstate = RUN;
      RUN: begin
        if (dp_ready)             nstate = DONE;
        else if (cnt == CNT_LAST) nstate = ABORT;
      end
      DONE:    nstate = IDLE;
      ABORT:   nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Registered outputs decoded from the next state, plus bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fresh   <= 1'b1;
      sel     <= 1'b0;
      last    <= 1'b1;
      cnt     <= '0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      err     <= 1'b0;
      result  <= '0;
      dp_load <= 1'b0;
      dp_busy <= 1'b0;
      dp_clr  <= 1'b0;
      dp_opa  <= '0;
      dp_opb  <= '0;
    end else begin
      fresh   <= 1'b0;
      gnt0    <= take && !win;
      gnt1    <= take && win;
      dp_load <= (nstate == LOAD);
      dp_busy <= (nstate == RUN);
      dp_clr  <= fresh || (nstate == DONE) || (nstate == ABORT);
      err     <= (nstate == ABORT);
      done0   <= (nstate == DONE) && !sel;
      done1   <= (nstate == DONE) && sel;
      if (take) begin
        sel    <= win;
        dp_opa <= win ? opa1 : opa0;
        dp_opb <= win ? opb1 : opb0;
      end
      if (state == LOAD)     cnt <= '0;
      else if (state == RUN) cnt <= cnt + 1'b1;
      if (nstate == DONE) result <= dp_mul;
      if (state == DONE || state == ABORT) last <= sel;
    end
  end

endmodule

// File: tb/tb_mul_arb_ctrl.sv
// Scoreboard bench for mul_arb_ctrl with a behavioural multiplier
// whose completion latency is set per operation.
module tb_mul_arb_ctrl;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
  } op_t;

  typedef struct {
    logic        ab;
    logic [15:0] p;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req0, req1;
  logic [7:0]  opa0, opb0, opa1, opb1;
  logic        gnt0, gnt1, done0, done1, err;
  logic [15:0] result;
  logic        dp_load, dp_busy, dp_clr;
  logic [7:0]  dp_opa, dp_opb;
  logic [15:0] dp_mul;
  logic        dp_ready;

  op_t   q0[$];
  op_t   q1[$];
  ent_t  e0[$];
  ent_t  e1[$];
  bit    gq[$];
  int    gaps[$];

  int checks = 0;
  int errors = 0;
  int lat = 1;
  int cyc = 0;
  int end_cyc = 0;
  int busy_n = 0;
  int run_len = 0;
  int excl_bad = 0;
  bit mon_en = 1'b0;
  bit cur = 1'b0;
  logic [15:0] last_res = '0;

  logic        m_ready = 1'b0;
  logic [15:0] m_prod = '0;
  int          m_cnt = 0;

  always #5 clk = ~clk;

  mul_arb_ctrl #(.WIDTH(8), .TIMEOUT(64)) dut (
    .clk(clk), .reset(rst_n),
    .req0(req0), .req1(req1),
    .opa0(opa0), .opb0(opb0), .opa1(opa1), .opb1(opb1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .err(err),
    .dp_load(dp_load), .dp_busy(dp_busy), .dp_clr(dp_clr),
    .dp_opa(dp_opa), .dp_opb(dp_opb),
    .dp_mul(dp_mul), .dp_ready(dp_ready)
  );

  assign dp_ready = m_ready;
  assign dp_mul   = m_ready ? m_prod : 16'd0;

  // Behavioural datapath: ready appears in RUN cycle index 'lat', sticky.
  always @(posedge clk) begin
    if (dp_clr) begin
      m_ready <= 1'b0;
      m_prod  <= '0;
    end else if (dp_load) begin
      m_prod  <= 16'(dp_opa) * 16'(dp_opb);
      m_cnt   <= lat;
      m_ready <= (lat == 0);
    end else if (dp_busy && !m_ready) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_ready <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic push_op(input bit r, input logic [7:0] a,
                         input logic [7:0] b, input logic ab);
    op_t  o;
    ent_t e;
    o.a  = a;
    o.b  = b;
    e.ab = ab;
    e.p  = 16'(a) * 16'(b);
    if (r) begin q1.push_back(o); e1.push_back(e); end
    else   begin q0.push_back(o); e0.push_back(e); end
  endtask

  // Requester 0: hold req until gnt, then reload or drop.
  initial begin
    op_t o;
    req0 = 1'b0; opa0 = '0; opb0 = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) req0 = 1'b0;
      else if (req0 && gnt0) begin
        if (q0.size() != 0) begin
          o = q0.pop_front(); opa0 = o.a; opb0 = o.b;
        end else req0 = 1'b0;
      end else if (!req0 && q0.size() != 0) begin
        o = q0.pop_front(); opa0 = o.a; opb0 = o.b; req0 = 1'b1;
      end
    end
  end

  // Requester 1.
  initial begin
    op_t o;
    req1 = 1'b0; opa1 = '0; opb1 = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) req1 = 1'b0;
      else if (req1 && gnt1) begin
        if (q1.size() != 0) begin
          o = q1.pop_front(); opa1 = o.a; opb1 = o.b;
        end else req1 = 1'b0;
      end else if (!req1 && q1.size() != 0) begin
        o = q1.pop_front(); opa1 = o.a; opb1 = o.b; req1 = 1'b1;
      end
    end
  end

  // Output monitor: grants, completions and aborts against the scoreboard.
  initial begin
    ent_t e;
    bit   have;
    forever begin
      @(negedge clk);
      cyc++;
      if (mon_en && rst_n) begin
        if (dp_load) busy_n = 0;
        if (dp_busy) busy_n++;
        if (int'(dp_load) + int'(dp_busy) + int'(dp_clr) > 1) excl_bad++;
        if (gnt0 || gnt1) begin
          cur = gnt1;
          gaps.push_back(cyc - end_cyc);
          chk("gnt_expected", gq.size() != 0, 1);
          if (gq.size() != 0) chk("gnt_order", gnt1, gq.pop_front());
        end
        if (done0 || done1) begin
          chk("done_who", done1, cur);
          have = done1 ? (e1.size() != 0) : (e0.size() != 0);
          chk("done_expected", have, 1);
          if (have) begin
            if (done1) e = e1.pop_front();
            else       e = e0.pop_front();
            chk("done_not_abort", e.ab, 0);
            chk("done_result", result, e.p);
            last_res = e.p;
          end
          chk("done_clr", dp_clr, 1);
          end_cyc = cyc;
          run_len = busy_n;
        end
        if (err) begin
          chk("err_nodone", done0 | done1, 0);
          have = cur ? (e1.size() != 0) : (e0.size() != 0);
          chk("err_expected", have, 1);
          if (have) begin
            if (cur) e = e1.pop_front();
            else     e = e0.pop_front();
            chk("err_is_abort", e.ab, 1);
          end
          chk("err_result_held", result, last_res);
          chk("err_clr", dp_clr, 1);
          end_cyc = cyc;
          run_len = busy_n;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_outs_zero", |{gnt0, gnt1, done0, done1, err, dp_load,
                           dp_busy, dp_clr, result, dp_opa, dp_opb}, 0);
    q0.delete(); q1.delete(); e0.delete(); e1.delete(); gq.delete();
    last_res = '0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_clr_pulse", dp_clr, 1);
    @(negedge clk);
    chk("rst_clr_end", dp_clr, 0);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || e0.size() != 0 ||
            e1.size() != 0 || req0 || req1) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", n < 300, 1);
    @(negedge clk);
    #1;
  endtask

  initial begin
    int n;
    do_reset();

    // Single request, 3 x 5.
    lat = 4;
    gq.push_back(1'b0);
    push_op(1'b0, 8'd3, 8'd5, 1'b0);
    wait_idle();
    chk("run_len_single", run_len, 5);

    // Tie right after reset: requester 0 first.
    do_reset();
    lat = 2;
    gq.push_back(1'b0);
    gq.push_back(1'b1);
    push_op(1'b0, 8'd7, 8'd9, 1'b0);
    push_op(1'b1, 8'd2, 8'd200, 1'b0);
    wait_idle();

    // Four back-to-back ties alternate, one IDLE cycle between.
    lat = 3;
    gaps.delete();
    gq.push_back(1'b0); gq.push_back(1'b1);
    gq.push_back(1'b0); gq.push_back(1'b1);
    push_op(1'b0, 8'd1, 8'd2, 1'b0);
    push_op(1'b0, 8'd3, 8'd4, 1'b0);
    push_op(1'b1, 8'd5, 8'd6, 1'b0);
    push_op(1'b1, 8'd7, 8'd8, 1'b0);
    wait_idle();
    chk("gap_count", gaps.size(), 4);
    for (int i = 1; i < 4; i++)
      if (i < gaps.size()) chk("gap_one_idle", gaps[i], 2);

    // Datapath never ready: abort after exactly 64 RUN cycles.
    lat = 1000000;
    gq.push_back(1'b0);
    push_op(1'b0, 8'd10, 8'd10, 1'b1);
    wait_idle();
    chk("run_len_timeout", run_len, 64);

    // Ready in the last allowed RUN cycle: completion wins.
    lat = 63;
    gq.push_back(1'b1);
    push_op(1'b1, 8'd12, 8'd11, 1'b0);
    wait_idle();
    chk("run_len_edge", run_len, 64);

    // Reset during RUN abandons the operation.
    lat = 20;
    gq.push_back(1'b0);
    push_op(1'b0, 8'd9, 8'd9, 1'b0);
    n = 0;
    while (!dp_busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("busy_seen", dp_busy, 1);
    repeat (3) @(negedge clk);
    do_reset();
    lat = 2;
    gq.push_back(1'b0);
    push_op(1'b0, 8'd255, 8'd255, 1'b0);
    wait_idle();
    chk("run_len_after_rst", run_len, 3);
    chk("result_after_rst", result, 16'd65025);

    chk("dp_strobes_exclusive", excl_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_arb_ctrl.md
MUL_ARB_CTRL -- requirements
Module: mul_arb_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: operand width of the shared shift-add multiplier datapath.
REQ-002 Parameter TIMEOUT, default 64: maximum RUN cycles before an operation is aborted.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 req0 / req1  input  1 each  requester 0/1 operation request; held high until matching gnt.
REQ-006 opa0, opb0 / opa1, opb1  input  WIDTH each  requester operands; valid while req high.
REQ-007 gnt0 / gnt1  output  1 each  one-cycle pulse: request accepted, operands captured.
REQ-008 done0 / done1  output  1 each  one-cycle pulse: result valid for that requester.
REQ-009 result  output  2*WIDTH  product of last completed operation; held until next completion.
REQ-010 err  output  1  one-cycle pulse on timeout abort.
REQ-011 dp_load  output  1  datapath operand load strobe.
REQ-012 dp_busy  output  1  datapath shift/accumulate enable.
REQ-013 dp_clr  output  1  datapath clear pulse (clears its sticky ready and product).
REQ-014 dp_opa / dp_opb  output  WIDTH each  operands driven to datapath.
REQ-015 dp_mul  input  2*WIDTH  datapath product.
REQ-016 dp_ready  input  1  datapath completion flag (sticky until cleared).

Function
REQ-017 FSM states SHALL be IDLE, LOAD, RUN, DONE, ABORT; all outputs registered.
REQ-018 IDLE: any req high -> arbitrate, latch winner's operands into internal regs, pulse winner's gnt in the next cycle, go to LOAD.
REQ-019 Arbitration: single req wins; both high -> grant the requester not served last; last-served pointer resets to 1 (so requester 0 wins first tie).
REQ-020 req inputs SHALL be ignored outside IDLE; a held req is re-arbitrated on return to IDLE.
REQ-021 LOAD lasts exactly 1 cycle: dp_load=1, dp_opa/dp_opb = latched operands; then RUN.
REQ-022 RUN: dp_busy=1, cycle counter increments each cycle starting from 0.
REQ-023 RUN with dp_ready=1 -> DONE (dp_ready takes priority over timeout in the same cycle).
REQ-024 RUN with counter == TIMEOUT-1 and dp_ready=0 -> ABORT.
REQ-025 DONE lasts 1 cycle: result <= dp_mul, pulse done of granted requester, pulse dp_clr, update last-served pointer, then IDLE.
REQ-026 ABORT lasts 1 cycle: pulse err, pulse dp_clr, result unchanged, no done pulse, update last-served pointer, then IDLE.
REQ-027 dp_load, dp_busy, dp_clr SHALL be mutually exclusive; all 0 in IDLE.
REQ-028 dp_opa/dp_opb SHALL hold latched operands from LOAD through DONE/ABORT.
REQ-029 Minimum request-to-done latency: 3 cycles plus RUN length; back-to-back service SHALL insert exactly one IDLE cycle.
REQ-030 Counter width SHALL hold TIMEOUT without wrap; counter cleared on entry to RUN.

Reset
REQ-031 reset low SHALL immediately force IDLE and clear counter, operand regs, result, gnt0/1, done0/1, err, dp_load, dp_busy, dp_opa, dp_opb to 0.
REQ-032 dp_clr SHALL be 0 during reset and pulse once in the first cycle after reset release.
REQ-033 reset mid-operation SHALL abandon the operation with no done or err pulse.

Verification
REQ-034 req0=1, opa0=3, opb0=5, behavioural datapath -> gnt0 pulse, dp_load 1 cycle, dp_busy until dp_ready, done0 pulse, result=15.
REQ-035 req0=req1=1 same cycle after reset, (7x9), (2x200) -> gnt0 first, result=63 with done0; then gnt1, result=400 with done1.
REQ-036 Four back-to-back ties -> grants alternate 0,1,0,1; one IDLE cycle between DONE and next gnt.
REQ-037 dp_ready tied 0, TIMEOUT=64 -> RUN exactly 64 cycles, err pulse, dp_clr pulse, result unchanged, no done.
REQ-038 reset low during RUN -> all outputs 0 asynchronously; after release dp_clr pulse, IDLE, next req served normally.
REQ-039 dp_ready and counter == TIMEOUT-1 in same cycle -> DONE taken, done pulse, no err.
